// File: rtl/phy_rx_demux_pkg.sv
// Shared types and constants for the PHY receive demultiplexer.
// Holds the aligner state encoding, the lane width and the default COM symbol.
// Imported by the interface, the aligner and the top-level demux.
package phy_rx_demux_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  localparam logic [LANE_W-1:0] COM_SYMBOL_DEF = 8'hBC;

  // One captured line slot: the byte and whether it was qualified.
  typedef struct packed {
    logic              vld;
    logic [LANE_W-1:0] dat;
  } lane_t;

  // Saturating 8-bit increment, used for the lock-loss counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/phy_rx_demux_if.sv
// Line-side input and demultiplexed-word output bundle of phy_rx_demux.
// master drives the serial byte stream and observes the lane word;
// slave (the demux) consumes the stream and presents the word and status.
interface phy_rx_demux_if;

  logic [phy_rx_demux_pkg::LANE_W-1:0] data_in;
  logic                                valid_in;
  logic [phy_rx_demux_pkg::LANE_W-1:0] data_out0;
  logic [phy_rx_demux_pkg::LANE_W-1:0] data_out1;
  logic [phy_rx_demux_pkg::LANE_W-1:0] data_out2;
  logic [phy_rx_demux_pkg::LANE_W-1:0] data_out3;
  logic                                valid_out0;
  logic                                valid_out1;
  logic                                valid_out2;
  logic                                valid_out3;
  logic                                word_strobe;
  logic                                locked;
  logic [7:0]                          lock_loss_cnt;

  modport master (
    output data_in, valid_in,
    input  data_out0, data_out1, data_out2, data_out3,
    input  valid_out0, valid_out1, valid_out2, valid_out3,
    input  word_strobe, locked, lock_loss_cnt
  );

  modport slave (
    input  data_in, valid_in,
    output data_out0, data_out1, data_out2, data_out3,
    output valid_out0, valid_out1, valid_out2, valid_out3,
    output word_strobe, locked, lock_loss_cnt
  );

endinterface

// File: rtl/phy_rx_aligner.sv
// COM-symbol alignment FSM: locks after COM_COUNT consecutive valid COM bytes,
// drops lock after IDLE_LIMIT consecutive idle cycles; slot counter runs while locked.
// Latency: locked/slot are registered (one cycle after the deciding sample); lock_drop is combinational.
module phy_rx_aligner
  import phy_rx_demux_pkg::*;
#(
  parameter logic [LANE_W-1:0] COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int                COM_COUNT  = 4,
  parameter int                IDLE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANE_W-1:0] data_in,
  input  logic              valid_in,
  output logic              locked,
  output logic [1:0]        slot,
  output logic              lock_drop
);

  localparam int CW = $clog2(COM_COUNT + 1);
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  localparam logic [CW-1:0] COM_LAST = CW'(COM_COUNT - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_LIMIT);

  state_e        state_q, state_d;
  logic [CW-1:0] com_q, com_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [IW-1:0] idle_inc;
  logic [1:0]    slot_q, slot_d;
  logic          com_hit;

  // Next-state, counter and lock-drop decode for the alignment FSM.
  always_comb begin
    state_d   = state_q;
    com_d     = com_q;
    idle_d    = idle_q;
    slot_d    = slot_q;
    lock_drop = 1'b0;
    com_hit   = valid_in && (data_in == COM_SYMBOL);
    idle_inc  = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;

    unique case (state_q)
      SEARCH: begin
        slot_d = '0;
        idle_d = '0;
        if (com_hit) begin
          if (com_q == COM_LAST) begin
            state_d = LOCKED;
            com_d   = '0;
          end else begin
            com_d = com_q + 1'b1;
          end
        end else begin
          com_d = '0;
        end
      end
      LOCKED: begin
        // Slot advances unconditionally so lane positions stay tied to line time.
        slot_d = slot_q + 2'd1;
        idle_d = valid_in ? '0 : idle_inc;
        if (!valid_in && (idle_inc == IDLE_MAX)) begin
          lock_drop = 1'b1;
          state_d   = SEARCH;
          slot_d    = '0;
          idle_d    = '0;
          com_d     = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // State and counter registers with synchronous reset into SEARCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      com_q   <= '0;
      idle_q  <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      com_q   <= com_d;
      idle_q  <= idle_d;
      slot_q  <= slot_d;
    end
  end

  assign locked = (state_q == LOCKED);
  assign slot   = slot_q;

endmodule

// File: rtl/phy_rx_demux.sv
// Serial-byte to 4-lane demultiplexer behind a COM-symbol aligner; optional lock-loss counter (PHY_RX_LOSSCNT_EN).
// Latency: word presented with a one-cycle word_strobe the cycle after its slot-3 byte is sampled.
// No backpressure: the line is never stalled; words lost to lock drop or reset are discarded silently.
module phy_rx_demux
  import phy_rx_demux_pkg::*;
#(
  parameter logic [LANE_W-1:0] COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int                COM_COUNT  = 4,
  parameter int                IDLE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  phy_rx_demux_if.slave      bus
);

  logic       locked;
  logic       lock_drop;
  logic [1:0] slot;

  lane_t cur;
  lane_t lane_q [3];
  lane_t lane_d [3];
  lane_t out_q  [NUM_LANES];
  lane_t out_d  [NUM_LANES];
  logic  strobe_q, strobe_d;

  phy_rx_aligner #(
    .COM_SYMBOL (COM_SYMBOL),
    .COM_COUNT  (COM_COUNT),
    .IDLE_LIMIT (IDLE_LIMIT)
  ) u_aligner (
    .clk       (clk),
    .reset     (reset),
    .data_in   (bus.data_in),
    .valid_in  (bus.valid_in),
    .locked    (locked),
    .slot      (slot),
    .lock_drop (lock_drop)
  );

  // Lane capture and word assembly; slot 3 goes straight to the output word.
  always_comb begin
    cur      = '{vld: bus.valid_in, dat: bus.data_in};
    lane_d   = lane_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    if (lock_drop) begin
      // Partial word (including one completing this cycle) is dropped.
      for (int i = 0; i < 3; i++) lane_d[i] = '0;
    end else if (locked) begin
      if (slot == 2'd3) begin
        for (int i = 0; i < 3; i++) out_d[i] = lane_q[i];
        out_d[3] = cur;
        strobe_d = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (slot == 2'(i)) lane_d[i] = cur;
        end
      end
    end
  end

  // Lane, output-word and strobe registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++)         lane_q[i] <= '0;
      for (int i = 0; i < NUM_LANES; i++) out_q[i]  <= '0;
      strobe_q <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef PHY_RX_LOSSCNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Count LOCKED->SEARCH transitions, saturating at all-ones.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_drop) loss_cnt_d = sat_inc8(loss_cnt_q);
  end

  // Lock-loss counter register.
  always_ff @(posedge clk) begin
    if (reset) loss_cnt_q <= '0;
    else       loss_cnt_q <= loss_cnt_d;
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`else
  assign bus.lock_loss_cnt = 8'h00;
`endif

  assign bus.data_out0   = out_q[0].dat;
  assign bus.data_out1   = out_q[1].dat;
  assign bus.data_out2   = out_q[2].dat;
  assign bus.data_out3   = out_q[3].dat;
  assign bus.valid_out0  = out_q[0].vld;
  assign bus.valid_out1  = out_q[1].vld;
  assign bus.valid_out2  = out_q[2].vld;
  assign bus.valid_out3  = out_q[3].vld;
  assign bus.word_strobe = strobe_q;
  assign bus.locked      = locked;

endmodule

// File: tb/tb_phy_rx_demux.sv
// Self-checking bench for phy_rx_demux: behavioural line model feeds a word scoreboard,
// a per-cycle monitor compares strobe/word/locked/loss count, scenario tasks add inline checks.
module tb_phy_rx_demux;
  import phy_rx_demux_pkg::*;

  localparam int          COM_COUNT  = 4;
  localparam int          IDLE_LIMIT = 8;
  localparam logic [7:0]  COM        = 8'hBC;
`ifdef PHY_RX_LOSSCNT_EN
  localparam logic [7:0]  EXP_ONE_LOSS = 8'h01;
  localparam logic [7:0]  EXP_SAT_LOSS = 8'hFF;
`else
  localparam logic [7:0]  EXP_ONE_LOSS = 8'h00;
  localparam logic [7:0]  EXP_SAT_LOSS = 8'h00;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  phy_rx_demux_if bus();

  phy_rx_demux #(
    .COM_SYMBOL (COM),
    .COM_COUNT  (COM_COUNT),
    .IDLE_LIMIT (IDLE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model of the line: state as it will be after the next rising edge.
  bit          m_locked;
  int          m_com, m_idle, m_slot, m_loss;
  logic [7:0]  m_ld [4];
  logic        m_lv [4];
  logic [35:0] m_out;
  logic [35:0] sb_q [$];
  logic [35:0] act;
  logic        exp_stb;

  function automatic logic [7:0] exp_loss();
`ifdef PHY_RX_LOSSCNT_EN
    return 8'(m_loss);
`else
    return 8'h00;
`endif
  endfunction

  task automatic drive(input logic [7:0] d, input logic v);
    @(negedge clk);
    reset        = 1'b0;
    bus.data_in  = d;
    bus.valid_in = v;
    if (!m_locked) begin
      if (v && d == COM) begin
        m_com++;
        if (m_com == COM_COUNT) begin
          m_locked = 1'b1; m_com = 0; m_slot = 0; m_idle = 0;
        end
      end else begin
        m_com = 0;
      end
    end else begin
      m_ld[m_slot] = d;
      m_lv[m_slot] = v;
      m_idle = v ? 0 : m_idle + 1;
      if (m_idle >= IDLE_LIMIT) begin
        m_locked = 1'b0; m_idle = 0; m_slot = 0; m_com = 0;
        if (m_loss < 255) m_loss++;
      end else begin
        if (m_slot == 3)
          sb_q.push_back({m_ld[3], m_ld[2], m_ld[1], m_ld[0], m_lv[3], m_lv[2], m_lv[1], m_lv[0]});
        m_slot = (m_slot + 1) % 4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b0;
    m_locked = 1'b0; m_com = 0; m_idle = 0; m_slot = 0; m_loss = 0;
    m_out = '0;
    sb_q.delete();
  endtask

  // Per-cycle monitor: strobe timing and word contents against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      exp_stb = (sb_q.size() != 0);
      n_checks++;
      if (bus.word_strobe !== exp_stb) begin
        n_fail++;
        $display("FAIL mon_strobe t=%0t actual=%b expected=%b", $time, bus.word_strobe, exp_stb);
      end
      if (exp_stb) m_out = sb_q.pop_front();
      act = {bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0,
             bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0};
      n_checks++;
      if (act !== m_out) begin
        n_fail++;
        $display("FAIL mon_word t=%0t actual=%h expected=%h", $time, act, m_out);
      end
      n_checks++;
      if (bus.locked !== m_locked) begin
        n_fail++;
        $display("FAIL mon_locked t=%0t actual=%b expected=%b", $time, bus.locked, m_locked);
      end
      n_checks++;
      if (bus.lock_loss_cnt !== exp_loss()) begin
        n_fail++;
        $display("FAIL mon_loss_cnt t=%0t actual=%h expected=%h", $time, bus.lock_loss_cnt, exp_loss());
      end
    end
  end

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked actual=%b expected=0", bus.locked); end
    n_checks++;
    if (bus.word_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe actual=%b expected=0", bus.word_strobe); end
    n_checks++;
    if ({bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0,
         bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0} !== 36'h0) begin
      n_fail++; $display("FAIL reset_outputs actual=%h%h%h%h expected=0", bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0);
    end
    n_checks++;
    if (bus.lock_loss_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_loss_cnt actual=%h expected=00", bus.lock_loss_cnt); end
  endtask

  task automatic test_lock();
    logic [7:0] pay [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(COM, 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (bus.locked !== (i == 3)) begin n_fail++; $display("FAIL lock_rise com=%0d actual=%b expected=%b", i, bus.locked, (i == 3)); end
    end
    for (int i = 0; i < 4; i++) drive(pay[i], 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (bus.word_strobe !== 1'b1) begin n_fail++; $display("FAIL lock_strobe actual=%b expected=1", bus.word_strobe); end
    n_checks++;
    if ({bus.data_out0, bus.data_out1, bus.data_out2, bus.data_out3} !== 32'h11223344) begin
      n_fail++; $display("FAIL lock_data actual=%h%h%h%h expected=11223344", bus.data_out0, bus.data_out1, bus.data_out2, bus.data_out3);
    end
    n_checks++;
    if ({bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0} !== 4'b1111) begin
      n_fail++; $display("FAIL lock_valids actual=%b%b%b%b expected=1111", bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0);
    end
  endtask

  task automatic test_partial_valid();
    drive(8'hAA, 1'b1);
    drive(8'h5A, 1'b0);
    drive(8'hCC, 1'b1);
    drive(8'hDD, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if ({bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0} !== 4'b1101) begin
      n_fail++; $display("FAIL partial_valids actual=%b%b%b%b expected=1101", bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0);
    end
    n_checks++;
    if ({bus.data_out0, bus.data_out2, bus.data_out3} !== 24'hAACCDD) begin
      n_fail++; $display("FAIL partial_data actual=%h,%h,%h expected=AA,CC,DD", bus.data_out0, bus.data_out2, bus.data_out3);
    end
  endtask

  task automatic test_broken_search();
    logic [7:0] seq [8] = '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(seq[i], 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (bus.locked !== (i == 7)) begin n_fail++; $display("FAIL broken_search byte=%0d actual=%b expected=%b", i, bus.locked, (i == 7)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       v;
    for (int i = 0; i < 24; i++) begin
      if (i % 5 == 2) begin d = COM; v = 1'b1; end
      else begin d = 8'($urandom_range(0, 255)); v = ($urandom_range(0, 3) != 0); end
      drive(d, v);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.word_strobe !== 1'b1 || bus.data_out3 !== d) begin
      n_fail++; $display("FAIL b2b_last_word strobe=%b data3=%h expected strobe=1 data3=%h", bus.word_strobe, bus.data_out3, d);
    end
  endtask

  task automatic test_idle_loss();
    do_reset();
    for (int i = 0; i < 4; i++) drive(COM, 1'b1);
    for (int i = 0; i < IDLE_LIMIT; i++) begin
      drive(8'h00, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (bus.locked !== (i < IDLE_LIMIT - 1)) begin
        n_fail++; $display("FAIL idle_locked idle=%0d actual=%b expected=%b", i + 1, bus.locked, (i < IDLE_LIMIT - 1));
      end
    end
    n_checks++;
    if (bus.word_strobe !== 1'b0) begin n_fail++; $display("FAIL idle_drop_strobe actual=%b expected=0", bus.word_strobe); end
    n_checks++;
    if (bus.lock_loss_cnt !== EXP_ONE_LOSS) begin n_fail++; $display("FAIL idle_loss_cnt actual=%h expected=%h", bus.lock_loss_cnt, EXP_ONE_LOSS); end
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < 4; i++) drive(COM, 1'b1);
    drive(8'h12, 1'b1); drive(8'h34, 1'b1); drive(8'h56, 1'b1); drive(8'h78, 1'b1);
    drive(8'h9A, 1'b1); drive(8'hBD, 1'b1);
    do_reset();
    @(posedge clk); #1;
    n_checks++;
    if (bus.locked !== 1'b0 || bus.word_strobe !== 1'b0) begin
      n_fail++; $display("FAIL midreset_status locked=%b strobe=%b expected 0,0", bus.locked, bus.word_strobe);
    end
    n_checks++;
    if ({bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0,
         bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0} !== 36'h0) begin
      n_fail++; $display("FAIL midreset_outputs actual=%h%h%h%h expected=0", bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0);
    end
    drive(8'hEE, 1'b1); drive(8'hFF, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (bus.word_strobe !== 1'b0) begin n_fail++; $display("FAIL midreset_no_strobe actual=%b expected=0", bus.word_strobe); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      for (int i = 0; i < 4; i++) drive(COM, 1'b1);
      for (int i = 0; i < IDLE_LIMIT; i++) drive(8'h00, 1'b0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.lock_loss_cnt !== EXP_SAT_LOSS) begin n_fail++; $display("FAIL sat_loss_cnt actual=%h expected=%h", bus.lock_loss_cnt, EXP_SAT_LOSS); end
  endtask

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b0;
    test_reset();
    test_lock();
    test_partial_valid();
    test_broken_search();
    test_back_to_back();
    test_idle_loss();
    test_reset_mid_word();
    test_saturation();
    for (int i = 0; i < 4; i++) drive(8'h00, 1'b0);
    @(posedge clk); #2;
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain pending=%0d expected=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phy_rx_demux.md
PHY_RX_DEMUX -- requirements
Module: phy_rx_demux

Interface
REQ-001 The block SHALL have parameter COM_SYMBOL, default 8'hBC, the alignment symbol.
REQ-002 The block SHALL have parameter COM_COUNT, default 4, the number of consecutive valid COM bytes needed to lock.
REQ-003 The block SHALL have parameter IDLE_LIMIT, default 8, the number of consecutive cycles with valid_in low that drops lock.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port data_in, input, 8 bits: serial byte stream from the line.
REQ-007 The block SHALL have port valid_in, input, 1 bit: data_in qualifier for the current slot.
REQ-008 The block SHALL have ports data_out0..data_out3, output, 8 bits each: demultiplexed lane bytes.
REQ-009 The block SHALL have ports valid_out0..valid_out3, output, 1 bit each: per-lane valid of the presented word.
REQ-010 The block SHALL have port word_strobe, output, 1 bit: one-cycle pulse when a new 4-lane word is presented.
REQ-011 The block SHALL have port locked, output, 1 bit: high while in state LOCKED.
REQ-012 The block SHALL have port lock_loss_cnt, output, 8 bits: count of lock losses (see Configuration).

Function
REQ-013 The block SHALL implement FSM states SEARCH and LOCKED; reset enters SEARCH.
REQ-014 In SEARCH, a com counter SHALL increment on each cycle with valid_in=1 and data_in=COM_SYMBOL, and clear to 0 on any other cycle.
REQ-015 When the COM_COUNT-th consecutive COM is sampled in cycle N, the state SHALL be LOCKED in cycle N+1, with slot=0 at N+1.
REQ-016 In LOCKED, a 2-bit slot counter SHALL advance every cycle (0,1,2,3,0...), regardless of valid_in.
REQ-017 Each cycle in LOCKED, data_in and valid_in SHALL be captured into lane[slot]; COM bytes are passed verbatim as data.
REQ-018 When slot=3 is captured in cycle N, data_out0..3 and valid_out0..3 SHALL update in cycle N+1, with word_strobe high for cycle N+1 only.
REQ-019 Between strobes, outputs SHALL hold the last presented word.
REQ-020 A word SHALL be presented even if some or all lane valids are 0.
REQ-021 In LOCKED, an idle counter SHALL count consecutive cycles with valid_in=0 and clear whenever valid_in=1.
REQ-022 When the idle counter reaches IDLE_LIMIT in cycle N, the state SHALL be SEARCH in cycle N+1.
REQ-023 Partially filled lanes SHALL be discarded on lock loss.
REQ-024 If lock is lost in the cycle slot=3 is captured, that word SHALL be discarded: no strobe, outputs unchanged.
REQ-025 On re-entering SEARCH, the com and slot counters SHALL be cleared.
REQ-026 The idle counter SHALL saturate at IDLE_LIMIT and never wrap.

Reset
REQ-027 While reset=1 at a clock edge, the next state SHALL be SEARCH.
REQ-028 While reset=1 at a clock edge, all data_out* and valid_out* SHALL become 0, word_strobe=0, locked=0 and lock_loss_cnt=0.
REQ-029 While reset=1 at a clock edge, all internal counters and lane registers SHALL become 0.
REQ-030 Reset asserted mid-word SHALL discard the partial word with no strobe.

Configuration
REQ-031 With macro PHY_RX_LOSSCNT_EN defined, lock_loss_cnt SHALL increment by 1 on each LOCKED->SEARCH transition, saturating at 8'hFF.
REQ-032 Without PHY_RX_LOSSCNT_EN, lock_loss_cnt SHALL be tied to 8'h00 and no counter logic SHALL be synthesized.

Structure
REQ-033 A shared package/include file SHALL hold the state encoding (SEARCH=0, LOCKED=1), the COM_SYMBOL default 8'hBC and the lane width 8.
REQ-034 The COM-search FSM with its com counter and idle counter SHALL be the sub-module phy_rx_aligner, outputting locked and slot.
REQ-035 The lane capture and output registers SHALL reside in phy_rx_demux.

Verification
REQ-036 Lock: 4 consecutive valid 8'hBC, then 11,22,33,44 all valid -> locked=1 after the 4th COM, then word_strobe one cycle after 44 with data_out0..3=11,22,33,44 and valid_out=1111.
REQ-037 Broken search: BC,BC,BC,55,BC,BC,BC,BC -> locked rises only after the 8th byte.
REQ-038 Partial valid: locked, send AA(v=1),--(v=0),CC(v=1),DD(v=1) -> valid_out0..3=1,0,1,1 with data_out0,2,3=AA,CC,DD.
REQ-039 Idle loss: locked, 8 cycles valid_in=0 -> locked=0 the next cycle, no strobe on the dropped word; with PHY_RX_LOSSCNT_EN, lock_loss_cnt=1.
REQ-040 Reset mid-word: locked, 2 lane bytes captured, reset=1 for 1 cycle -> all outputs 0, locked=0, no strobe.
REQ-041 Saturation: with PHY_RX_LOSSCNT_EN, 260 lock/loss cycles -> lock_loss_cnt=8'hFF.
